// File: rtl/eth_mmio_arbiter.sv
// eth_mmio_arbiter: round-robin sharing of the single-ported ethernet_controller
// MMIO interface between num_req_p requesters. One operation is in flight at a
// time: accept -> one-cycle strobe -> (read) bounded wait -> one-cycle response.
`timescale 1ns/1ps

module eth_mmio_arbiter #(
   parameter int num_req_p    = 2,
   parameter int data_width_p = 32,
   parameter int addr_width_p = 14,
   parameter int size_width_p = 2,
   parameter int timeout_p    = 16
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,

   input  logic [num_req_p-1:0]              req_v_i,
   output logic [num_req_p-1:0]              req_ready_o,
   input  logic [num_req_p-1:0]              req_we_i,
   input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
   input  logic [num_req_p*size_width_p-1:0] req_size_i,
   input  logic [num_req_p*data_width_p-1:0] req_data_i,

   output logic [num_req_p-1:0]              resp_v_o,
   output logic [data_width_p-1:0]           resp_data_o,
   output logic                              resp_err_o,

   output logic [addr_width_p-1:0]           addr_o,
   output logic [size_width_p-1:0]           op_size_o,
   output logic [data_width_p-1:0]           write_data_o,
   output logic                              write_en_o,
   output logic                              read_en_o,
   input  logic [data_width_p-1:0]           read_data_i,
   input  logic                              read_data_v_i,

   output logic [7:0]                        timeout_cnt_o
);

   localparam int idx_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int cnt_w_lp = $clog2(timeout_p + 1);
   localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(num_req_p - 1);
   // Final WAIT cycle: the counter starts at 0, so timeout_p cycles end at timeout_p-1.
   localparam logic [cnt_w_lp-1:0] wait_last_lp = cnt_w_lp'(timeout_p - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e                  state_q;
   logic [idx_w_lp-1:0]     grant_q;
   logic [idx_w_lp-1:0]     last_grant_q;
   logic                    we_q;
   logic [cnt_w_lp-1:0]     wait_cnt_q;

   logic [addr_width_p-1:0] addr_q;
   logic [size_width_p-1:0] size_q;
   logic [data_width_p-1:0] wdata_q;
   logic                    write_en_q;
   logic                    read_en_q;
   logic [num_req_p-1:0]    resp_v_q;
   logic [data_width_p-1:0] resp_data_q;
   logic                    resp_err_q;
   logic [7:0]              timeout_cnt_q;

   // Round-robin selection and unpacked request views
   logic [idx_w_lp-1:0]     cand_d;
   logic [idx_w_lp-1:0]     grant_idx_d;
   logic                    grant_found_d;
   logic [num_req_p-1:0]    grant_oh_d;
   logic [num_req_p-1:0]    owner_oh_d;
   logic [addr_width_p-1:0] addr_arr_d [num_req_p];
   logic [size_width_p-1:0] size_arr_d [num_req_p];
   logic [data_width_p-1:0] data_arr_d [num_req_p];

   // Split the packed request buses into per-requester fields.
   always_comb begin
      for (int i = 0; i < num_req_p; i++) begin
         addr_arr_d[i] = req_addr_i[i*addr_width_p +: addr_width_p];
         size_arr_d[i] = req_size_i[i*size_width_p +: size_width_p];
         data_arr_d[i] = req_data_i[i*data_width_p +: data_width_p];
      end
   end

   // Pick the first valid requester after last_grant, wrapping; scanning from the
   // farthest candidate down lets the nearest valid one overwrite the others.
   always_comb begin
      cand_d        = '0;
      grant_idx_d   = '0;
      grant_found_d = 1'b0;
      for (int k = num_req_p; k >= 1; k--) begin
         cand_d = idx_w_lp'((int'(last_grant_q) + k) % num_req_p);
         if (req_v_i[cand_d]) begin
            grant_found_d = 1'b1;
            grant_idx_d   = cand_d;
         end
      end
   end

   // One-hot forms of the pending grant and of the current owner.
   always_comb begin
      grant_oh_d = '0;
      owner_oh_d = '0;
      if (grant_found_d) begin
         grant_oh_d[grant_idx_d] = 1'b1;
      end
      owner_oh_d[grant_q] = 1'b1;
   end

   // Grant is only offered while idle and out of reset; this is the sole
   // combinational output.
   assign req_ready_o = (reset_n_i && (state_q == S_IDLE)) ? grant_oh_d : '0;

   // Arbiter FSM with registered controller command and response outputs.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q       <= S_IDLE;
         grant_q       <= '0;
         last_grant_q  <= last_idx_lp;
         we_q          <= 1'b0;
         wait_cnt_q    <= '0;
         addr_q        <= '0;
         size_q        <= '0;
         wdata_q       <= '0;
         write_en_q    <= 1'b0;
         read_en_q     <= 1'b0;
         resp_v_q      <= '0;
         resp_data_q   <= '0;
         resp_err_q    <= 1'b0;
         timeout_cnt_q <= '0;
      end else begin
         write_en_q <= 1'b0;
         read_en_q  <= 1'b0;
         resp_v_q   <= '0;
         case (state_q)
            S_IDLE: begin
               if (grant_found_d) begin
                  grant_q      <= grant_idx_d;
                  last_grant_q <= grant_idx_d;
                  we_q         <= req_we_i[grant_idx_d];
                  addr_q       <= addr_arr_d[grant_idx_d];
                  size_q       <= size_arr_d[grant_idx_d];
                  wdata_q      <= data_arr_d[grant_idx_d];
                  // Strobe is registered so it appears in the ISSUE cycle.
                  write_en_q   <= req_we_i[grant_idx_d];
                  read_en_q    <= !req_we_i[grant_idx_d];
                  state_q      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wait_cnt_q <= '0;
               if (we_q) begin
                  // Writes are posted: respond right away with no data.
                  resp_v_q    <= owner_oh_d;
                  resp_data_q <= '0;
                  resp_err_q  <= 1'b0;
                  state_q     <= S_RESP;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (read_data_v_i) begin
                  resp_v_q    <= owner_oh_d;
                  resp_data_q <= read_data_i;
                  resp_err_q  <= 1'b0;
                  state_q     <= S_RESP;
               end else if (wait_cnt_q == wait_last_lp) begin
                  resp_v_q    <= owner_oh_d;
                  resp_data_q <= '0;
                  resp_err_q  <= 1'b1;
                  if (timeout_cnt_q != 8'hFF) begin
                     timeout_cnt_q <= timeout_cnt_q + 8'd1;
                  end
                  state_q     <= S_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + cnt_w_lp'(1);
               end
            end
            S_RESP: begin
               resp_data_q <= '0;
               resp_err_q  <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign addr_o        = addr_q;
   assign op_size_o     = size_q;
   assign write_data_o  = wdata_q;
   assign write_en_o    = write_en_q;
   assign read_en_o     = read_en_q;
   assign resp_v_o      = resp_v_q;
   assign resp_data_o   = resp_data_q;
   assign resp_err_o    = resp_err_q;
   assign timeout_cnt_o = timeout_cnt_q;

endmodule

// File: tb/tb_eth_mmio_arbiter.sv
// Bench for eth_mmio_arbiter: directed scenarios with literal expectations plus a
// cycle-stamped transaction model checked against the DUT every cycle.
`timescale 1ns/1ps

module tb_eth_mmio_arbiter;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 14;
   localparam int SW = 2;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req_v, req_ready, req_we, resp_v;
   logic [N*AW-1:0] req_addr;
   logic [N*SW-1:0] req_size;
   logic [N*DW-1:0] req_data;
   logic [DW-1:0]   resp_data, write_data, rd_data;
   logic            resp_err, write_en, read_en, rd_v;
   logic [AW-1:0]   addr;
   logic [SW-1:0]   op_size;
   logic [7:0]      timeout_cnt;

   int     n_checks = 0;
   int     n_errors = 0;
   longint cyc = 0;
   bit     mon_en = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   eth_mmio_arbiter #(
      .num_req_p(N), .data_width_p(DW), .addr_width_p(AW),
      .size_width_p(SW), .timeout_p(TO)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .req_v_i(req_v), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_size_i(req_size), .req_data_i(req_data),
      .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_err_o(resp_err),
      .addr_o(addr), .op_size_o(op_size), .write_data_o(write_data),
      .write_en_o(write_en), .read_en_o(read_en),
      .read_data_i(rd_data), .read_data_v_i(rd_v),
      .timeout_cnt_o(timeout_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [SW-1:0] s, input logic [DW-1:0] d);
      req_we[i]             = we;
      req_addr[i*AW +: AW]  = a;
      req_size[i*SW +: SW]  = s;
      req_data[i*DW +: DW]  = d;
   endtask

   // ---------------- transaction model ----------------
   // One operation at a time, described by its accept cycle; the strobe is
   // due one cycle after accept, the response cycle is fixed by the op type,
   // the first read_data_v at or after accept+2, or the timeout deadline.
   bit            m_busy = 1'b0;
   longint        m_acc, m_resp;
   int            m_owner;
   int            m_last = N - 1;
   int            m_tocnt = 0;
   bit            m_we;
   logic [AW-1:0] m_addr;
   logic [SW-1:0] m_size;
   logic [DW-1:0] m_wdata, m_rdata;
   bit            m_err;

   always @(negedge clk) begin
      int           pick;
      logic [N-1:0] exp_ready, exp_resp;
      bit           exp_wr, exp_rd;
      if (mon_en) begin
         pick = -1;
         exp_ready = '0;
         if (!m_busy && reset_n) begin
            for (int k = 1; k <= N; k++) begin
               if (pick < 0 && req_v[(m_last + k) % N]) pick = (m_last + k) % N;
            end
            if (pick >= 0) exp_ready[pick] = 1'b1;
         end
         chk("model_ready", req_ready, exp_ready);

         exp_wr = m_busy && (cyc == m_acc + 1) && m_we;
         exp_rd = m_busy && (cyc == m_acc + 1) && !m_we;
         chk("model_write_en", write_en, exp_wr);
         chk("model_read_en", read_en, exp_rd);
         if (exp_wr || exp_rd) begin
            chk("model_addr", addr, m_addr);
            chk("model_size", op_size, m_size);
            chk("model_wdata", write_data, m_wdata);
         end

         exp_resp = '0;
         if (m_busy && cyc == m_resp) exp_resp[m_owner] = 1'b1;
         chk("model_resp_v", resp_v, exp_resp);
         if (exp_resp != '0) begin
            chk("model_resp_data", resp_data, m_rdata);
            chk("model_resp_err", resp_err, m_err);
         end
         chk("model_timeout_cnt", timeout_cnt, m_tocnt);

         // advance the model across the coming clock edge
         if (!reset_n) begin
            m_busy  = 1'b0;
            m_last  = N - 1;
            m_tocnt = 0;
         end else if (!m_busy) begin
            if (pick >= 0) begin
               m_busy  = 1'b1;
               m_acc   = cyc;
               m_owner = pick;
               m_last  = pick;
               m_we    = req_we[pick];
               m_addr  = req_addr[pick*AW +: AW];
               m_size  = req_size[pick*SW +: SW];
               m_wdata = req_data[pick*DW +: DW];
               m_rdata = '0;
               m_err   = 1'b0;
               m_resp  = m_we ? cyc + 2 : -1;
            end
         end else begin
            if (!m_we && m_resp < 0 && cyc >= m_acc + 2) begin
               if (rd_v) begin
                  m_resp  = cyc + 1;
                  m_rdata = rd_data;
               end else if (cyc == m_acc + 1 + TO) begin
                  m_resp  = cyc + 1;
                  m_err   = 1'b1;
                  if (m_tocnt < 255) m_tocnt = m_tocnt + 1;
               end
            end
            if (cyc == m_resp) m_busy = 1'b0;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      logic [AW-1:0] seq[$];
      logic [AW-1:0] exp_seq [6];
      int            n_to;

      reset_n = 1'b0; req_v = '0; req_we = '0; req_addr = '0; req_size = '0;
      req_data = '0; rd_v = 1'b0; rd_data = '0;
      next_cyc();
      mon_en = 1'b1;
      @(negedge clk);
      chk("reset_write_en", write_en, 0);
      chk("reset_read_en", read_en, 0);
      chk("reset_resp_v", resp_v, 0);
      chk("reset_timeout_cnt", timeout_cnt, 0);
      chk("reset_ready", req_ready, 0);
      next_cyc();
      reset_n = 1'b1;
      next_cyc();

      // single write from requester 0
      set_req(0, 1'b1, 14'h010, 2'd2, 32'hDEADBEEF);
      req_v = 2'b01;
      @(negedge clk); chk("wr_ready", req_ready, 2'b01);
      next_cyc(); req_v = '0;
      @(negedge clk);
      chk("wr_strobe", write_en, 1);
      chk("wr_no_read", read_en, 0);
      chk("wr_addr", addr, 14'h010);
      chk("wr_size", op_size, 2'd2);
      chk("wr_data", write_data, 32'hDEADBEEF);
      next_cyc();
      @(negedge clk);
      chk("wr_resp_v", resp_v, 2'b01);
      chk("wr_resp_err", resp_err, 0);
      chk("wr_resp_data", resp_data, 0);
      next_cyc(); next_cyc();

      // single read from requester 1
      set_req(1, 1'b0, 14'h020, 2'd2, 32'h0);
      req_v = 2'b10;
      @(negedge clk); chk("rd_ready", req_ready, 2'b10);
      next_cyc(); req_v = '0;
      @(negedge clk);
      chk("rd_strobe", read_en, 1);
      chk("rd_addr", addr, 14'h020);
      next_cyc(); rd_v = 1'b1; rd_data = 32'h12345678;
      @(negedge clk); chk("rd_no_early_resp", resp_v, 2'b00);
      next_cyc(); rd_v = 1'b0; rd_data = '0;
      @(negedge clk);
      chk("rd_resp_v", resp_v, 2'b10);
      chk("rd_resp_data", resp_data, 32'h12345678);
      chk("rd_resp_err", resp_err, 0);
      next_cyc(); next_cyc();

      // contention: both valid for six writes
      set_req(0, 1'b1, 14'h100, 2'd2, 32'hA0A0A0A0);
      set_req(1, 1'b1, 14'h200, 2'd2, 32'hB1B1B1B1);
      exp_seq = '{14'h100, 14'h200, 14'h100, 14'h200, 14'h100, 14'h200};
      req_v = 2'b11;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         if (write_en) seq.push_back(addr);
         next_cyc();
      end
      req_v = '0;
      next_cyc(); next_cyc();
      chk("rr_op_count", seq.size(), 6);
      for (int i = 0; i < 6 && i < seq.size(); i++) chk("rr_order", seq[i], exp_seq[i]);

      // read timeout, then a late read_data_v that must be ignored
      set_req(0, 1'b0, 14'h030, 2'd0, 32'h0);
      req_v = 2'b01;
      @(negedge clk); chk("to_ready", req_ready, 2'b01);
      next_cyc(); req_v = '0;
      for (int i = 0; i < 17; i++) next_cyc();
      @(negedge clk);
      chk("to_resp_v", resp_v, 2'b01);
      chk("to_resp_err", resp_err, 1);
      chk("to_resp_data", resp_data, 0);
      chk("to_count", timeout_cnt, 1);
      next_cyc(); next_cyc();
      rd_v = 1'b1; rd_data = 32'hCAFEF00D;
      next_cyc(); rd_v = 1'b0; rd_data = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("late_no_resp", resp_v, 2'b00);
         next_cyc();
      end

      // reset while a read waits
      set_req(0, 1'b1, 14'h040, 2'd1, 32'h11111111);
      set_req(1, 1'b0, 14'h050, 2'd0, 32'h0);
      req_v = 2'b10;
      @(negedge clk); chk("rst_pre_ready", req_ready, 2'b10);
      next_cyc(); req_v = '0;
      next_cyc(); next_cyc(); next_cyc();
      reset_n = 1'b0; req_v = 2'b11;
      @(negedge clk); chk("rst_ready_low", req_ready, 2'b00);
      next_cyc(); reset_n = 1'b1;
      @(negedge clk);
      chk("rst_write_en", write_en, 0);
      chk("rst_read_en", read_en, 0);
      chk("rst_resp_v", resp_v, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_addr", addr, 0);
      chk("rst_size", op_size, 0);
      chk("rst_wdata", write_data, 0);
      chk("rst_timeout_cnt", timeout_cnt, 0);
      chk("rst_first_grant", req_ready, 2'b01);
      next_cyc(); req_v = '0;
      @(negedge clk);
      chk("rst_first_strobe", write_en, 1);
      chk("rst_first_addr", addr, 14'h040);
      next_cyc(); next_cyc(); next_cyc();

      // 260 back-to-back timeouts saturate the counter
      set_req(0, 1'b0, 14'h060, 2'd0, 32'h0);
      req_v = 2'b01;
      n_to = 0;
      for (int i = 0; i < 6000 && n_to < 260; i++) begin
         @(negedge clk);
         if (resp_v[0] && resp_err) n_to++;
         if (n_to < 260) next_cyc();
      end
      next_cyc(); req_v = '0;
      chk("sat_timeouts_seen", n_to, 260);
      @(negedge clk); chk("sat_count", timeout_cnt, 8'd255);
      next_cyc(); next_cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
